// File: rtl/sub_pkg.sv
// Shared state encoding and half/full subtractor functions for the bit-serial
// subtractor; hs/fs are also meant for a future ripple-borrow subtractor.
package sub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Returns {borrow, difference}.
    function automatic logic [1:0] hs(input logic x, input logic y);
        return {~x & y, x ^ y};
    endfunction

    function automatic logic [1:0] fs(input logic x, input logic y, input logic bi);
        logic [1:0] h1;
        logic [1:0] h2;
        h1 = hs(x, y);
        h2 = hs(h1[0], bi);
        return {h1[1] | h2[1], h2[0]};
    endfunction

endpackage

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock under a start/busy/done
// handshake; diff/borrow/ovf hold the last completed result.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_w_q, a_w_d;
    logic [WIDTH-1:0] b_w_q, b_w_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [1:0]       bit_res;

    always_comb begin
        state_d  = state_q;
        a_w_d    = a_w_q;
        b_w_d    = b_w_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        bit_res  = fs(a_w_q[0], b_w_q[0], bin_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_w_d   = a;
                    b_w_d   = b;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    res_d   = '0;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d = {bit_res[0], res_q[WIDTH-1:1]};
                a_w_d = a_w_q >> 1;
                b_w_d = b_w_q >> 1;
                bin_d = bit_res[1];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Overflow uses the operand MSBs captured at start, since
                    // the working registers have been shifted out by now.
                    diff_d   = res_d;
                    borrow_d = bit_res[1];
                    ovf_d    = (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_w_q    <= '0;
            b_w_q    <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_w_q    <= a_w_d;
            b_w_q    <= b_w_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor at WIDTH=4.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [3:0] diff;
    logic       borrow;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts a run at the next posedge, then checks busy for 4 cycles, the done
    // pulse after E4, the result, and that it holds after done drops.
    task automatic run_op(input string nm, input logic [3:0] av, input logic [3:0] bv,
                          input logic [3:0] ed, input logic eb, input logic eo);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        a = ~av; b = ~bv;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if ({busy, done} !== 2'b10) begin
                bad++;
                $display("FAIL %s run_cycle%0d busy/done=%b%b want 10", nm, k, busy, done);
            end
        end
        @(negedge clk);
        total++;
        if ({busy, done, diff, borrow, ovf} !== {2'b01, ed, eb, eo}) begin
            bad++;
            $display("FAIL %s result busy=%b done=%b diff=%b borrow=%b ovf=%b want busy=0 done=1 diff=%b borrow=%b ovf=%b",
                     nm, busy, done, diff, borrow, ovf, ed, eb, eo);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if ({busy, done, diff, borrow, ovf} !== {2'b00, ed, eb, eo}) begin
                bad++;
                $display("FAIL %s hold%0d busy=%b done=%b diff=%b borrow=%b ovf=%b want 0 0 %b %b %b",
                         nm, k, busy, done, diff, borrow, ovf, ed, eb, eo);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, diff, borrow, ovf} !== 8'b0) begin
            bad++;
            $display("FAIL reset busy=%b done=%b diff=%b borrow=%b ovf=%b want all 0",
                     busy, done, diff, borrow, ovf);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_op("basic", 4'b0101, 4'b0010, 4'b0011, 1'b0, 1'b0);
        run_op("borrow", 4'b0010, 4'b0101, 4'b1101, 1'b1, 1'b0);
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        @(negedge clk);
        a = 4'b1100; b = 4'b0100; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 4'b1111; b = 4'b0000; start = 1'b1;
        // Held through the remaining RUN edges and the DONE edge.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        start = 1'b0;
        total++;
        if (dones != 1 || diff !== 4'b1000 || borrow !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL ignore_start dones=%0d diff=%b borrow=%b ovf=%b want 1 1000 0 0",
                     dones, diff, borrow, ovf);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        total++;
        if (dones != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_no_queue dones=%0d busy=%b want 1 0", dones, busy);
        end
    endtask

    task automatic test_overflow();
        run_op("ovf_pos", 4'b0111, 4'b1000, 4'b1111, 1'b1, 1'b1);
        run_op("ovf_neg", 4'b1001, 4'b0011, 4'b0110, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        int dones = 0;
        @(negedge clk);
        a = 4'b0110; b = 4'b0001; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, done, diff, borrow, ovf} !== 8'b0) begin
            bad++;
            $display("FAIL async_reset busy=%b done=%b diff=%b borrow=%b ovf=%b want all 0",
                     busy, done, diff, borrow, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL abandoned_run active_cycles=%0d want 0", dones);
        end
        run_op("after_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int idx[$];
        @(negedge clk);
        a = 4'b0011; b = 4'b0001; start = 1'b1;
        for (int n = 0; n < 18; n++) begin
            @(negedge clk);
            if (done) begin
                idx.push_back(n);
                total++;
                if (diff !== 4'b0010 || borrow !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_result n=%0d diff=%b borrow=%b want 0010 0", n, diff, borrow);
                end
            end
        end
        start = 1'b0;
        total++;
        if (idx.size() != 3) begin
            bad++;
            $display("FAIL b2b_count dones=%0d want 3", idx.size());
        end else if (idx[0] != 4 || idx[1] != 10 || idx[2] != 16) begin
            bad++;
            $display("FAIL b2b_spacing at %0d,%0d,%0d want 4,10,16", idx[0], idx[1], idx[2]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_overflow();
        test_async_reset();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
